v_lane_sequencer: RTL and testbench
===================================

V_LANE_SEQUENCER -- requirements
Module: v_lane_sequencer

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1: cycles from issue to ALU writeback, legal 1..7.
REQ-002 SHALL have parameter MUL_LAT, default 2: cycles from issue to MUL writeback, legal 1..7.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Ports, in order:
- clk  in  1  rising-edge clock.
- nrst  in  1  asynchronous reset, active-high (despite the name).
- alu_req_valid  in  1  ALU operation pending.
- alu_req_ready  out  1  ALU request accepted this cycle.
- mul_req_valid  in  1  MUL operation pending.
- mul_req_ready  out  1  MUL request accepted this cycle.
- cfg_lmul  in  3  register groups per op: 0 gives 1, 1 gives 2, 2 gives 4, other values give 1.
- cfg_lanes  in  2  groups per pass: 0 gives 1 (4 lanes), 1 gives 2 (8 lanes), 2 or 3 gives 4 (16 lanes).
- flush  in  1  synchronous abort.
- issue_valid  out  1  operand-select strobe.
- issue_unit  out  1  0 = ALU, 1 = MUL.
- issue_step  out  2  first register group of this pass.
- issue_mask  out  4  groups active this pass.
- wb_valid  out  1  results of the current pass are ready to capture.
- wb_step  out  2  issue_step of the pass being written back.
- wb_mask  out  4  issue_mask of the pass being written back.
- done_alu  out  1  one-cycle pulse, ALU op complete.
- done_mul  out  1  one-cycle pulse, MUL op complete.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-005 States SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-006 In IDLE, the block SHALL grant exactly one valid requester and assert only that requester's ready for that single cycle; ready is combinational and asserted only in IDLE.
REQ-007 When both requesters are valid, arbitration SHALL be round-robin: the unit not granted last wins; after reset ALU has priority.
REQ-008 On grant, the block SHALL latch unit, G = groups and P = groups per pass, clear pass index k, and move to ISSUE; cfg changes after grant SHALL have no effect on the op in flight.
REQ-009 In ISSUE (one cycle):
- issue_valid = 1, issue_unit = latched unit.
- issue_step = k*P.
- issue_mask = bits [issue_step .. min(issue_step+P, G)-1] set.
- load counter with the latched unit's LAT, then go to WAIT.
REQ-010 In WAIT, the counter SHALL decrement each cycle. When counter = 1: wb_valid = 1 with wb_step and wb_mask of that pass. Then: if (k+1)*P < G, increment k and go to ISSUE; otherwise go to DONE.
REQ-011 DONE SHALL pulse done_alu or done_mul (matching the latched unit) for one cycle, then go to IDLE; no grant occurs in DONE.
REQ-012 Passes = ceil(G/P). Accept cycle T gives done at T + passes*(LAT+1) + 1.
REQ-013 flush SHALL force IDLE at the next edge and drop pending wb_valid and done; it SHALL NOT change round-robin priority. flush in IDLE SHALL block grant that cycle.
REQ-014 When state is not IDLE, the block SHALL hold both ready outputs low regardless of valid.
REQ-015 issue_valid, wb_valid and done outputs SHALL never be high in the same cycle as each other.

Reset
REQ-016 While nrst is high, asynchronously:
- state = IDLE, k = 0, counter = 0, priority = ALU.
- all outputs 0 (ready outputs 0).
REQ-017 Reset mid-operation SHALL abandon the op with no done pulse; the first grant is possible in the first cycle after nrst falls.

Verification
REQ-018 ALU only, lmul=0, lanes=0, accept at T -> issue T+1 (step 0, mask 0001), wb T+2, done_alu T+3.
REQ-019 MUL, lmul=2, lanes=0, MUL_LAT=2 -> 4 issues with steps 0,1,2,3 and masks 0001,0010,0100,1000, each wb 2 cycles after its issue, done_mul at T+13.
REQ-020 ALU, lmul=2, lanes=1 -> issues step 0 mask 0011 and step 2 mask 1100; lmul=0, lanes=2 -> single issue with mask 0001.
REQ-021 Both requesters valid continuously -> grants alternate ALU, MUL, ALU; ready is never asserted while busy.
REQ-022 flush during WAIT of pass 2 of 4 -> IDLE at the next edge, no wb_valid or done; the next request completes normally.
REQ-023 nrst asserted mid-WAIT -> all outputs 0 immediately; after release, ALU wins a simultaneous request.

Source files
------------

// File: rtl/v_lane_sequencer.sv
// v_lane_sequencer: round-robin ALU/MUL sequencer that splits one op into register-group passes.
module v_lane_sequencer #(
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       alu_req_valid,
  output logic       alu_req_ready,
  input  logic       mul_req_valid,
  output logic       mul_req_ready,
  input  logic [2:0] cfg_lmul,
  input  logic [1:0] cfg_lanes,
  input  logic       flush,
  output logic       issue_valid,
  output logic       issue_unit,
  output logic [1:0] issue_step,
  output logic [3:0] issue_mask,
  output logic       wb_valid,
  output logic [1:0] wb_step,
  output logic [3:0] wb_mask,
  output logic       done_alu,
  output logic       done_mul,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic unit, pri_mul, gnt, gnt_mul, more;
  logic [1:0] k;
  logic [2:0] g, p, cnt, step;
  logic [3:0] mask;
  assign gnt_mul = mul_req_valid && (!alu_req_valid || pri_mul);
  assign gnt = state == IDLE && !nrst && !flush && (alu_req_valid || mul_req_valid);
  assign alu_req_ready = gnt && !gnt_mul;
  assign mul_req_ready = gnt && gnt_mul;
  assign step = {1'b0, k} * p;
  assign more = step + p < g;
  always_comb begin
    mask = '0;
    for (int i = 0; i < 4; i++)
      mask[i] = 3'(i) >= step && 3'(i) < step + p && 3'(i) < g;
  end
  assign issue_valid = state == ISSUE;
  assign issue_unit = issue_valid && unit;
  assign issue_step = issue_valid ? step[1:0] : 2'd0;
  assign issue_mask = issue_valid ? mask : 4'd0;
  assign wb_valid = state == WAIT && cnt == 3'd1;
  assign wb_step = wb_valid ? step[1:0] : 2'd0;
  assign wb_mask = wb_valid ? mask : 4'd0;
  assign done_alu = state == DONE && !unit;
  assign done_mul = state == DONE && unit;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state <= IDLE;
      k <= '0;
      cnt <= '0;
      pri_mul <= 1'b0;
      unit <= 1'b0;
      g <= '0;
      p <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (gnt) begin
          unit <= gnt_mul;
          pri_mul <= !gnt_mul;
          g <= cfg_lmul == 3'd1 ? 3'd2 : cfg_lmul == 3'd2 ? 3'd4 : 3'd1;
          p <= cfg_lanes == 2'd0 ? 3'd1 : cfg_lanes == 2'd1 ? 3'd2 : 3'd4;
          k <= '0;
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= unit ? 3'(MUL_LAT) : 3'(ALU_LAT);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            k <= more ? k + 2'd1 : k;
            state <= more ? ISSUE : DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_v_lane_sequencer.sv
// tb_v_lane_sequencer: random and directed stimulus against a pass-schedule model of the sequencer.
module tb_v_lane_sequencer;
  localparam int ALU_LAT = 1;
  localparam int MUL_LAT = 2;
  logic clk = 0, nrst = 1, av = 0, mv = 0, flush = 0;
  logic [2:0] lmul = 0;
  logic [1:0] lanes = 0;
  logic alu_req_ready, mul_req_ready, issue_valid, issue_unit, wb_valid, done_alu, done_mul, busy;
  logic [1:0] issue_step, wb_step;
  logic [3:0] issue_mask, wb_mask;
  int checks = 0, errors = 0, cyc = 0;
  bit act = 0, pri = 0, m_unit = 0;
  int t0, mg, mp, ml, tend;
  logic [5:0] iss_q[$];
  bit gq[$];
  int acc_cyc, done_cyc, nwb, ndone;

  v_lane_sequencer #(.ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .nrst(nrst), .alu_req_valid(av), .alu_req_ready(alu_req_ready),
    .mul_req_valid(mv), .mul_req_ready(mul_req_ready), .cfg_lmul(lmul), .cfg_lanes(lanes),
    .flush(flush), .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_step(issue_step),
    .issue_mask(issue_mask), .wb_valid(wb_valid), .wb_step(wb_step), .wb_mask(wb_mask),
    .done_alu(done_alu), .done_mul(done_mul), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int grp(input logic [2:0] l);
    return l == 3'd0 ? 1 : l == 3'd1 ? 2 : l == 3'd2 ? 4 : 1;
  endfunction

  function automatic int gpp(input logic [1:0] l);
    return l == 2'd0 ? 1 : l == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [19:0] outs();
    return {alu_req_ready, mul_req_ready, issue_valid, issue_unit, issue_step, issue_mask,
            wb_valid, wb_step, wb_mask, done_alu, done_mul, busy};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Expected outputs follow from the accept cycle: each pass takes LAT+1 cycles, done one cycle after the last.
  task automatic step_cycle();
    logic ear, emr, eiv, eiu, ewv, eda, edm, ebusy;
    logic [1:0] eis, ews;
    logic [3:0] eim, ewm, mk;
    logic [19:0] e;
    int rel, j, off, s;
    bit gm;
    @(negedge clk);
    {ear, emr, eiv, eiu, ewv, eda, edm, ebusy} = '0;
    {eis, ews, eim, ewm, mk} = '0;
    gm = mv && (!av || pri);
    if (!nrst) begin
      if (act) begin
        rel = cyc - t0;
        ebusy = 1;
        if (rel == tend) begin
          eda = !m_unit;
          edm = m_unit;
        end else begin
          j = (rel - 1) / (ml + 1);
          off = (rel - 1) % (ml + 1);
          s = j * mp;
          for (int i = 0; i < 4; i++) mk[i] = i >= s && i < s + mp && i < mg;
          if (off == 0) begin eiv = 1; eiu = m_unit; eis = 2'(s); eim = mk; end
          if (off == ml) begin ewv = 1; ews = 2'(s); ewm = mk; end
        end
      end else if (!flush && (av || mv)) begin
        ear = !gm;
        emr = gm;
      end
    end
    e = {ear, emr, eiv, eiu, eis, eim, ewv, ews, ewm, eda, edm, ebusy};
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL cycle %0d outputs got %h expected %h", cyc, outs(), e);
    end
    if (alu_req_ready || mul_req_ready) begin acc_cyc = cyc; gq.push_back(mul_req_ready); end
    if (issue_valid) iss_q.push_back({issue_step, issue_mask});
    if (wb_valid) nwb++;
    if (done_alu || done_mul) begin ndone++; done_cyc = cyc; end
    if (nrst) begin
      act = 0;
      pri = 0;
    end else if (flush) begin
      act = 0;
    end else if (!act && (av || mv)) begin
      act = 1;
      t0 = cyc;
      m_unit = gm;
      pri = !gm;
      mg = grp(lmul);
      mp = gpp(lanes);
      ml = gm ? MUL_LAT : ALU_LAT;
      tend = ((mg + mp - 1) / mp) * (ml + 1) + 1;
    end else if (act && cyc - t0 == tend) begin
      act = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit a, input bit m, input logic [2:0] lm, input logic [1:0] ln);
    av = a; mv = m; lmul = lm; lanes = ln;
    iss_q.delete();
    acc_cyc = -1;
    done_cyc = -1;
    step_cycle();
    av = 0; mv = 0; lmul = 3'($urandom); lanes = 2'($urandom);
    for (int i = 0; i < 100 && done_cyc < 0; i++) step_cycle();
  endtask

  initial begin
    step_cycle();
    step_cycle();
    chk("reset_busy", busy, 0);
    chk("reset_outs", int'(outs()), 0);
    nrst = 0;
    run_op(1, 0, 0, 0);
    chk("alu_latency", done_cyc - acc_cyc, 3);
    chk("alu_passes", iss_q.size(), 1);
    chk("alu_issue", iss_q[0], 6'b00_0001);
    run_op(0, 1, 2, 0);
    chk("mul_latency", done_cyc - acc_cyc, 13);
    chk("mul_passes", iss_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("mul_issue%0d", i), iss_q[i], (i << 4) | (1 << i));
    run_op(1, 0, 2, 1);
    chk("lanes8_latency", done_cyc - acc_cyc, 5);
    chk("lanes8_issue0", iss_q[0], 6'b00_0011);
    chk("lanes8_issue1", iss_q[1], 6'b10_1100);
    run_op(1, 0, 0, 2);
    chk("lanes16_passes", iss_q.size(), 1);
    chk("lanes16_issue", iss_q[0], 6'b00_0001);
    av = 0; mv = 1; lmul = 2; lanes = 0;
    iss_q.delete();
    step_cycle();
    mv = 0;
    for (int i = 0; i < 20 && iss_q.size() < 2; i++) step_cycle();
    flush = 1;
    step_cycle();
    flush = 0;
    nwb = 0;
    ndone = 0;
    repeat (6) step_cycle();
    chk("flush_wb", nwb, 0);
    chk("flush_done", ndone, 0);
    chk("flush_busy", busy, 0);
    run_op(1, 0, 0, 0);
    chk("after_flush_latency", done_cyc - acc_cyc, 3);
    mv = 1; lmul = 2;
    step_cycle();
    mv = 0;
    repeat (3) step_cycle();
    nrst = 1;
    #1;
    chk("async_reset_outs", int'(outs()), 0);
    step_cycle();
    nrst = 0; av = 1; mv = 1; lmul = 0; lanes = 0;
    gq.delete();
    repeat (25) step_cycle();
    av = 0; mv = 0;
    chk("rr_grant0", gq[0], 0);
    chk("rr_grant1", gq[1], 1);
    chk("rr_grant2", gq[2], 0);
    repeat (3000) begin
      av = ($urandom % 3) == 0;
      mv = ($urandom % 3) == 0;
      lmul = 3'($urandom);
      lanes = 2'($urandom);
      flush = ($urandom % 40) == 0;
      nrst = ($urandom % 300) == 0;
      step_cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
